// File: rtl/counter_ud_ctrl_pkg.sv
// counter_ud_ctrl_pkg: shared types for the counter_ud sequencer/arbiter.
//   op_e    : requester command encoding (HOLD, LOAD, UP, DOWN)
//   state_e : controller FSM states
//   OP_W    : width of one requester's op field
package counter_ud_ctrl_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True for the ops that step the counter.
  function automatic logic is_step_op(input op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/counter_ud_ctrl_rr_arbiter.sv
// counter_ud_ctrl_rr_arbiter: combinational NUM_REQ-way round-robin pick.
// Ports:
//   i_req       : request vector
//   i_ptr       : index with highest priority this round
//   o_grant     : one-hot grant (all zero when no request)
//   o_grant_idx : index of the granted requester
//   o_any       : at least one request present
module counter_ud_ctrl_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any
);

  // Scan from i_ptr upward with wrap; first hit wins.
  always_comb begin
    int unsigned k;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    k           = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(i_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!o_any && i_req[k]) begin
        o_any       = 1'b1;
        o_grant[k]  = 1'b1;
        o_grant_idx = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/counter_ud_ctrl.sv
// counter_ud_ctrl: shares one counter_ud (no enable, parallel load) between
// NUM_REQ requesters. One command at a time is granted round-robin, executed
// on the counter, and answered with the resulting count.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_ready        : per-requester command handshake (ready = grant pulse)
//   req_op/req_data/req_len    : per-requester packed command fields
//   resp_valid/resp_ready      : response handshake
//   resp_id/resp_count/resp_wrap : response owner, count, wrap/saturate flag
//   busy                       : command in flight
//   cnt_load_en/cnt_load/cnt_down : controls to the attached counter
//   cnt_count/cnt_rollover     : state from the attached counter
// Build option: define CNT_CTRL_SAT_EN for saturating UP/DOWN.
module counter_ud_ctrl
  import counter_ud_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LEN_W   = 4,
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [OP_W*NUM_REQ-1:0]  req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_data,
  input  logic [LEN_W*NUM_REQ-1:0] req_len,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_count,
  output logic                     resp_wrap,
  output logic                     busy,
  output logic                     cnt_load_en,
  output logic [WIDTH-1:0]         cnt_load,
  output logic                     cnt_down,
  input  logic [WIDTH-1:0]         cnt_count,
  input  logic                     cnt_rollover
);

  state_e             r_state;
  op_e                r_op;
  logic [WIDTH-1:0]   r_data;
  logic [LEN_W-1:0]   r_remain;
  logic [ID_W-1:0]    r_owner;
  logic [ID_W-1:0]    r_ptr;
  logic               r_wrap;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any;
  op_e                w_win_op;
  logic [WIDTH-1:0]   w_win_data;
  logic [LEN_W-1:0]   w_win_len;
  logic [ID_W-1:0]    w_next_ptr;
  logic               w_step;
  logic               w_at_edge;
  logic               w_sat;
  logic               w_take;
  logic               w_exec_load;

  counter_ud_ctrl_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Winner's command fields.
  assign w_win_op   = op_e'(req_op[32'(w_grant_idx)*OP_W +: OP_W]);
  assign w_win_data = req_data[32'(w_grant_idx)*WIDTH +: WIDTH];
  assign w_win_len  = req_len[32'(w_grant_idx)*LEN_W +: LEN_W];

  assign w_next_ptr = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(r_owner + 1'b1);

  // A pending UP/DOWN step and whether it crosses the wrap boundary.
  assign w_step    = (r_state == ST_EXEC) && is_step_op(r_op) && (r_remain != '0);
  assign w_at_edge = (r_op == OP_UP) ? cnt_rollover : (cnt_count == '0);

`ifdef CNT_CTRL_SAT_EN
  assign w_sat = w_step && w_at_edge;
`else
  assign w_sat = 1'b0;
`endif

  // Counter moves only on a taken step; every other cycle reloads itself.
  assign w_take      = w_step && !w_sat && !rst;
  assign w_exec_load = (r_state == ST_EXEC) && (r_op == OP_LOAD) && !rst;

  assign cnt_load_en = !w_take;
  assign cnt_load    = w_exec_load ? r_data : cnt_count;
  assign cnt_down    = w_take && (r_op == OP_DOWN);

  assign req_ready  = ((r_state == ST_IDLE) && !rst) ? w_grant : '0;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_id    = r_owner;
  assign resp_count = cnt_count;
  assign resp_wrap  = r_wrap;
  assign busy       = (r_state != ST_IDLE);

  // Controller FSM and command latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_HOLD;
      r_data   <= '0;
      r_remain <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_wrap   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_op     <= w_win_op;
            r_data   <= w_win_data;
            r_remain <= w_win_len;
            r_owner  <= w_grant_idx;
            r_wrap   <= 1'b0;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!w_step) begin
            r_state <= ST_RESP;
          end else if (w_sat) begin
            r_wrap  <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            if (w_at_edge) r_wrap <= 1'b1;
            r_remain <= r_remain - LEN_W'(1);
            if (r_remain == LEN_W'(1)) r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
            r_ptr   <= w_next_ptr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/counter_ud_ctrl.md
Name: counter_ud_ctrl

Overview:
Sequencer and round-robin arbiter that shares one counter_ud instance (up/down counter with parallel load and all-ones rollover flag) between NUM_REQ requesters. Each requester issues one command at a time: LOAD a value, count UP or DOWN for N steps, or HOLD. The block drives the counter's load/load_en/down controls and returns the resulting count per command.

Parameters:
WIDTH, 4, counter width; must match the attached counter_ud
NUM_REQ, 2, number of requesters (>=2)
LEN_W, 4, width of the step-count field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  one-hot accept pulse
req_op  in  2*NUM_REQ  per-requester op: 0 HOLD, 1 LOAD, 2 UP, 3 DOWN
req_data  in  WIDTH*NUM_REQ  per-requester load value
req_len  in  LEN_W*NUM_REQ  per-requester step count
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_id  out  max(1,$clog2(NUM_REQ))  owner of the response
resp_count  out  WIDTH  counter value after the command
resp_wrap  out  1  command crossed the wrap boundary
busy  out  1  state != IDLE
cnt_load_en  out  1  to counter load enable
cnt_load  out  WIDTH  to counter load value
cnt_down  out  1  to counter direction
cnt_count  in  WIDTH  from counter count
cnt_rollover  in  1  from counter rollover (&count)

Behaviour:
- Counter has no enable. "Hold" is implemented as cnt_load_en=1, cnt_load=cnt_count.
- Counter controls are a combinational decode of registered state only. There is no comb path from req_* inputs.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Counter held.
  - If any req_valid: pick the first valid at or after rr_ptr (wrapping).
  - Pulse req_ready[winner] for 1 cycle. Latch op, data, len and owner.
  - Clear wrap_flag. Go to EXEC next cycle.
- EXEC, LOAD: 1 cycle with cnt_load_en=1, cnt_load=latched data. Then go to RESP.
- EXEC, HOLD, or UP/DOWN with len=0: 1 cycle with counter held. Then go to RESP.
- EXEC, UP/DOWN with len>0:
  - cnt_load_en=0, cnt_down=(op==DOWN).
  - Decrement remaining each cycle; exactly len counter steps occur. Go to RESP after the step where remaining==1.
  - Set wrap_flag on any UP step taken while cnt_rollover=1, or any DOWN step taken while cnt_count==0.
  - Arithmetic is modulo 2^WIDTH.
- RESP:
  - Counter held.
  - resp_valid=1. resp_count=cnt_count (registered counter, already updated). resp_id=owner. resp_wrap=wrap_flag.
  - Outputs stable until resp_ready.
  - On resp_valid&&resp_ready: go to IDLE, rr_ptr<=owner+1 (mod NUM_REQ).
- Arbitration is only in IDLE. There is at most one outstanding command system-wide. A requester may drop req_valid before grant.
- Latency: grant-to-resp_valid = 2 cycles for LOAD/HOLD and 1+len cycles for UP/DOWN.
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_count=cnt_count pass-through, resp_wrap=0, busy=0, cnt_load_en=1, cnt_load=cnt_count.
- Reset mid-EXEC or mid-RESP aborts the command with no response. The counter's own reset is separate.
- resp_ready asserted while resp_valid=0 is ignored.

Optional Feature:
CNT_CTRL_SAT_EN
- Defined: saturating mode. An UP step with cnt_rollover=1, or a DOWN step with cnt_count==0, is not taken. The counter is held that cycle and EXEC ends early into RESP with resp_wrap=1, meaning saturated. resp_count is all-ones or 0 respectively.
- Undefined: wrap-around as described above; resp_wrap is informational only.

Decomposition:
- counter_ud_ctrl_pkg: op enum (OP_HOLD, OP_LOAD, OP_UP, OP_DOWN), state enum (ST_IDLE, ST_EXEC, ST_RESP), op field width constant.
- Sub-module rr_arbiter: NUM_REQ-way round-robin, req vector + ptr in, one-hot grant + index out, purely combinational.

Test Plan:
- Reset, no requests -> busy=0, cnt_load_en=1, counter value unchanged over 10 cycles.
- Req0 LOAD data=9 -> req_ready[0] pulse, resp after 2 cycles: resp_count=9, resp_id=0, resp_wrap=0.
- From 9, req1 UP len=3 -> resp_count=12, resp_id=1. Latency from grant = 4 cycles.
- From 14, UP len=4 -> resp_count=2 with resp_wrap=1. With CNT_CTRL_SAT_EN: resp_count=15, resp_wrap=1, ended after 1 step.
- Both req_valid held continuously, 4 commands -> grants alternate 0,1,0,1. resp_ready held low 5 cycles -> resp outputs stable, no new grant.
- Assert rst during EXEC of DOWN len=8 -> state IDLE next cycle, no resp_valid, rr_ptr=0. Next grant goes to req0.
